// File: rtl/hdmi_rx_frame_writer.sv
// HDMI receive frame capture: buffers ADV7611 pixels between two VS edges
// in a small FIFO and streams them as single-word Avalon writes to LPDDR2.
module hdmi_rx_frame_writer #(
    parameter logic [26:0] BASE_ADDR      = 27'h0,
    parameter int          FIFO_DEPTH     = 16,
    parameter bit          VS_ACTIVE_HIGH = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture_en,
    input  logic        local_init_done,
    input  logic        vid_vs,
    input  logic        vid_de,
    input  logic [23:0] vid_d,
    input  logic        avl_waitrequest_n,
    output logic [26:0] avl_address,
    output logic [31:0] avl_writedata,
    output logic        avl_write,
    output logic        avl_burstbegin,
    output logic [2:0]  avl_size,
    output logic        capture_busy,
    output logic        capture_done,
    output logic        overflow,
    output logic [23:0] words_written
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_VS, S_CAPTURE, S_DRAIN, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic          vs_act, vs_q, edge_q;
    logic [23:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          arm, push_req, full, push, pop, write_side;
    logic          wr_q, wr_d, bb_q, bb_d;
    logic [26:0]   addr_q, addr_d;
    logic          ovf_q, ovf_d;
    logic [23:0]   words_q, words_d;

    assign vs_act = VS_ACTIVE_HIGH ? vid_vs : ~vid_vs;

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            vs_q   <= vs_act;
            edge_q <= vs_act & ~vs_q;
        end
    end

    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (capture_en && local_init_done) begin
                    state_d = S_WAIT_VS;
                    arm     = 1'b1;
                end
            end
            S_WAIT_VS: if (edge_q) state_d = S_CAPTURE;
            S_CAPTURE: if (edge_q) state_d = S_DRAIN;
            S_DRAIN:   if (count_q == '0 && !wr_q) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign push_req   = (state_q == S_CAPTURE) && !edge_q && vid_de;
    assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
    assign push       = push_req && !full;
    assign pop        = wr_q && avl_waitrequest_n;
    assign write_side = (state_q == S_CAPTURE) || (state_q == S_DRAIN);

    // Request is driven from entries already counted before this edge,
    // so a pixel reaches the bus two cycles after its DE cycle.
    always_comb begin
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        wr_d    = write_side && ((count_q - (AW+1)'(pop)) != '0);
        bb_d    = wr_d && (!wr_q || pop);
        addr_d  = arm ? BASE_ADDR : addr_q + 27'(pop);
        words_d = words_q;
        if (arm) begin
            words_d = '0;
        end else if (pop && words_q != 24'hFFFFFF) begin
            words_d = words_q + 24'd1;
        end
        ovf_d = arm ? 1'b0 : (ovf_q | (push_req && full));
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= vid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_q     <= 1'b0;
            bb_q     <= 1'b0;
            addr_q   <= BASE_ADDR;
            ovf_q    <= 1'b0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q  <= count_d;
            wr_q     <= wr_d;
            bb_q     <= bb_d;
            addr_q   <= addr_d;
            ovf_q    <= ovf_d;
            words_q  <= words_d;
        end
    end

    assign avl_address    = addr_q;
    assign avl_writedata  = wr_q ? {8'h00, mem_q[rd_ptr_q]} : 32'h0;
    assign avl_write      = wr_q;
    assign avl_burstbegin = bb_q;
    assign avl_size       = 3'b001;
    assign capture_busy   = (state_q == S_WAIT_VS) ||
                            (state_q == S_CAPTURE) ||
                            (state_q == S_DRAIN);
    assign capture_done   = (state_q == S_DONE);
    assign overflow       = ovf_q;
    assign words_written  = words_q;

endmodule

// File: tb/tb_hdmi_rx_frame_writer.sv
// Randomised bench for hdmi_rx_frame_writer with a queue-based frame model
// and a per-cycle compare process.
module tb_hdmi_rx_frame_writer;
    localparam logic [26:0] BASE  = 27'h7FFFFFC;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset, capture_en, local_init_done;
    logic        vid_vs, vid_de;
    logic [23:0] vid_d;
    logic        rdy = 1'b1;
    logic [26:0] avl_address;
    logic [31:0] avl_writedata;
    logic        avl_write, avl_burstbegin;
    logic [2:0]  avl_size;
    logic        capture_busy, capture_done, overflow;
    logic [23:0] words_written;

    always #5 clk = ~clk;

    hdmi_rx_frame_writer #(
        .BASE_ADDR(BASE),
        .FIFO_DEPTH(DEPTH),
        .VS_ACTIVE_HIGH(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .capture_en(capture_en),
        .local_init_done(local_init_done),
        .vid_vs(vid_vs),
        .vid_de(vid_de),
        .vid_d(vid_d),
        .avl_waitrequest_n(rdy),
        .avl_address(avl_address),
        .avl_writedata(avl_writedata),
        .avl_write(avl_write),
        .avl_burstbegin(avl_burstbegin),
        .avl_size(avl_size),
        .capture_busy(capture_busy),
        .capture_done(capture_done),
        .overflow(overflow),
        .words_written(words_written)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Frame model: 0 idle, 1 armed, 2 in frame, 3 draining, 4 done
    int          phase = 0;
    int          cyc = 0;
    logic [23:0] q_pix[$];
    int          q_t[$];
    int          acc_n = 0;
    bit          m_ovf = 0;
    bit          vs1 = 0, vs2 = 0;
    bit          prev_wr = 0, prev_rdy = 0, prev_rst = 0;
    logic [26:0] prev_addr;
    logic [31:0] prev_data;
    int          done_pulses = 0;
    int          bb_count = 0;
    logic [26:0] acc_addr[$];
    logic [31:0] acc_data[$];

    always @(negedge clk) begin
        bit edge_now, pix_ok, accept;
        cyc++;
        if (prev_rst) begin
            chk("rst_write", avl_write, 0);
            chk("rst_bb", avl_burstbegin, 0);
            chk("rst_addr", avl_address, BASE);
            chk("rst_data", avl_writedata, 0);
            chk("rst_words", words_written, 0);
        end
        chk("size", avl_size, 3'b001);
        chk("busy", capture_busy, phase >= 1 && phase <= 3);
        chk("done", capture_done, phase == 4);
        chk("overflow", overflow, m_ovf);
        chk("words", words_written, 24'(acc_n));
        if (capture_done) done_pulses++;
        if (avl_burstbegin) bb_count++;
        if (avl_write) begin
            if (q_pix.size() == 0) begin
                chk("write_when_empty", 1, 0);
            end else begin
                chk("write_latency", (cyc - q_t[0]) >= 2, 1);
                chk("wdata", avl_writedata, {8'h00, q_pix[0]});
            end
            chk("waddr", avl_address, 27'(BASE + 27'(acc_n)));
            chk("burstbegin", avl_burstbegin, !(prev_wr && !prev_rdy));
        end else begin
            chk("bb_idle", avl_burstbegin, 0);
        end
        if (prev_wr && !prev_rdy && !prev_rst) begin
            chk("stall_write", avl_write, 1);
            chk("stall_addr", avl_address, prev_addr);
            chk("stall_data", avl_writedata, prev_data);
        end
        if ((phase == 2 || phase == 3) && q_pix.size() > 0 &&
            (cyc - q_t[0]) >= 3)
            chk("write_pending", avl_write, 1);

        accept = avl_write && rdy;
        if (reset) begin
            phase = 0;
            q_pix.delete();
            q_t.delete();
            acc_n = 0;
            m_ovf = 0;
            vs1 = 0;
            vs2 = 0;
        end else begin
            edge_now = vs1 && !vs2;
            pix_ok = 0;
            case (phase)
                0: if (capture_en && local_init_done) begin
                    phase = 1;
                    acc_n = 0;
                    m_ovf = 0;
                    acc_addr.delete();
                    acc_data.delete();
                end
                1: if (edge_now) phase = 2;
                2: if (edge_now) phase = 3; else pix_ok = vid_de;
                3: if (q_pix.size() == 0 && !avl_write) phase = 4;
                default: phase = 0;
            endcase
            if (pix_ok) begin
                if (q_pix.size() >= DEPTH) begin
                    m_ovf = 1;
                end else begin
                    q_pix.push_back(vid_d);
                    q_t.push_back(cyc);
                end
            end
            if (accept) begin
                acc_addr.push_back(avl_address);
                acc_data.push_back(avl_writedata);
                if (q_pix.size() > 0) begin
                    void'(q_pix.pop_front());
                    void'(q_t.pop_front());
                end
                acc_n++;
            end
            vs2 = vs1;
            vs1 = vid_vs;
        end
        prev_wr   = avl_write;
        prev_rdy  = rdy;
        prev_rst  = reset;
        prev_addr = avl_address;
        prev_data = avl_writedata;
    end

    // 0 always ready, 1 random, 2 held off, 3 stall first write 5 cycles
    int rmode = 0;
    int stall = 0;
    always begin
        @(posedge clk);
        #1;
        case (rmode)
            0: rdy = 1'b1;
            1: rdy = 1'($urandom_range(0, 1));
            2: rdy = 1'b0;
            default: begin
                if (stall >= 5) begin
                    rdy = 1'b1;
                end else begin
                    rdy = 1'b0;
                    if (avl_write) stall++;
                end
            end
        endcase
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm();
        capture_en = 1'b1;
        tick(1);
        capture_en = 1'b0;
        tick(2);
    endtask

    task automatic vs_pulse();
        vid_de = 1'b0;
        vid_vs = 1'b1;
        tick(2);
        vid_vs = 1'b0;
        tick(2);
    endtask

    task automatic pixels(input int n, input bit seq, input int base,
                          input bit gaps);
        for (int i = 0; i < n; i++) begin
            vid_de = 1'b1;
            vid_d  = seq ? 24'(base + i) : 24'($urandom);
            tick(1);
            vid_de = 1'b0;
            if (gaps) tick($urandom_range(0, 2));
        end
    endtask

    task automatic wait_done(input int start);
        int b = 0;
        while (done_pulses == start && b < 3000) begin
            tick(1);
            b++;
        end
        chk("done_timeout", done_pulses != start, 1);
        tick(3);
    endtask

    task automatic capture(input int npre, input int n, input bit seq,
                           input int base, input bit gaps, input int npost);
        int start;
        start = done_pulses;
        arm();
        pixels(npre, 0, 0, 0);
        vs_pulse();
        pixels(n, seq, base, gaps);
        vs_pulse();
        pixels(npost, 0, 0, 0);
        wait_done(start);
    endtask

    initial begin
        int d0, b0;
        reset = 1'b1;
        capture_en = 1'b0;
        local_init_done = 1'b1;
        vid_vs = 1'b0;
        vid_de = 1'b0;
        vid_d = '0;
        tick(3);
        reset = 1'b0;
        tick(2);

        // Eight sequential pixels, always ready, address wraps
        rmode = 0;
        d0 = done_pulses;
        capture(0, 8, 1, 1, 0, 0);
        chk("s1_words", words_written, 24'd8);
        chk("s1_count", acc_data.size(), 8);
        chk("s1_addr0", acc_addr[0], 27'h7FFFFFC);
        chk("s1_addr4", acc_addr[4], 27'h0000000);
        chk("s1_addr7", acc_addr[7], 27'h0000003);
        chk("s1_data0", acc_data[0], 32'h00000001);
        chk("s1_data7", acc_data[7], 32'h00000008);
        chk("s1_done_pulses", done_pulses - d0, 1);

        // First write stalled five cycles
        stall = 0;
        rmode = 3;
        b0 = bb_count;
        capture(0, 3, 1, 'h100, 0, 0);
        chk("s2_words", words_written, 24'd3);
        chk("s2_bursts", bb_count - b0, 3);
        chk("s2_data0", acc_data[0], 32'h00000100);
        rmode = 0;

        // Ready held off across 20 pixels
        rmode = 2;
        d0 = done_pulses;
        arm();
        vs_pulse();
        pixels(20, 1, 1, 0);
        vs_pulse();
        chk("s3_overflow", overflow, 1);
        rmode = 0;
        wait_done(d0);
        chk("s3_words", words_written, 24'd16);
        chk("s3_count", acc_data.size(), 16);
        chk("s3_data0", acc_data[0], 32'h00000001);
        chk("s3_data15", acc_data[15], 32'h00000010);

        // Pixels outside the frame; init_done drops mid-capture
        rmode = 1;
        d0 = done_pulses;
        arm();
        pixels(5, 0, 0, 0);
        vs_pulse();
        pixels(4, 0, 0, 1);
        local_init_done = 1'b0;
        pixels(6, 0, 0, 1);
        local_init_done = 1'b1;
        vs_pulse();
        pixels(5, 0, 0, 0);
        wait_done(d0);
        chk("s4_words", words_written, 24'd10);
        rmode = 0;

        // Reset during a stalled write
        rmode = 2;
        arm();
        vs_pulse();
        pixels(3, 1, 'h40, 0);
        tick(3);
        chk("s5_pre_write", avl_write, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("s5_write_dropped", avl_write, 0);
        chk("s5_idle", capture_busy, 0);
        rmode = 0;
        tick(5);
        chk("s5_no_write", avl_write, 0);

        // Arm request without controller ready
        local_init_done = 1'b0;
        capture_en = 1'b1;
        tick(3);
        chk("s6_not_armed", capture_busy, 0);
        capture_en = 1'b0;
        local_init_done = 1'b1;
        tick(2);

        // Random captures
        for (int it = 0; it < 6; it++) begin
            rmode = $urandom_range(0, 1);
            capture($urandom_range(0, 3), $urandom_range(1, 40), 0, 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
